// File: rtl/uart_pkg.sv
// Shared definitions for the parameterised UART core: parity modes, FSM
// state encodings and the oversample-counter width helper.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // Width of a counter that must hold 0 .. ovs-1.
    function automatic int ovs_cnt_w(input int ovs);
        return (ovs <= 2) ? 1 : $clog2(ovs);
    endfunction

endpackage

// File: rtl/uart_rx.sv
// UART receive path: 2-flop line synchroniser plus an oversampling RX FSM
// that samples every bit at mid-bit and reports data and error flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int PARITY_MODE = 0,
    parameter int OVS         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              rx_in,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err
);

    localparam int            CW        = ovs_cnt_w(OVS);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OVS - 1);

    logic              sync1, sync2;
    rx_state_t         state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [3:0]        bit_cnt, bit_cnt_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              par_bad, par_bad_n;
    logic [DATA_W-1:0] data_n;
    logic              valid_n, perr_n, ferr_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1      <= 1'b1;
            sync2      <= 1'b1;
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            sync1      <= rx_in;
            sync2      <= sync1;
            state      <= state_n;
            cnt        <= cnt_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            par_bad    <= par_bad_n;
            data       <= data_n;
            valid      <= valid_n;
            parity_err <= perr_n;
            frame_err  <= ferr_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        par_bad_n = par_bad;
        data_n    = data;
        valid_n   = 1'b0;
        perr_n    = parity_err;
        ferr_n    = frame_err;
        if (tick) begin
            case (state)
                RX_IDLE: begin
                    if (!sync2) begin
                        state_n = RX_START;
                        cnt_n   = '0;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        // Line back high at mid start bit means it was a glitch.
                        cnt_n     = '0;
                        bit_cnt_n = '0;
                        state_n   = sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL_LAST) begin
                        cnt_n   = '0;
                        shreg_n = {sync2, shreg[DATA_W-1:1]};
                        if (bit_cnt == 4'(DATA_W - 1))
                            state_n = (PARITY_MODE == PARITY_NONE) ? RX_STOP : RX_PARITY;
                        else
                            bit_cnt_n = bit_cnt + 4'd1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                RX_PARITY: begin
                    if (cnt == FULL_LAST) begin
                        cnt_n     = '0;
                        par_bad_n = (^shreg) ^ sync2 ^ (PARITY_MODE == PARITY_ODD);
                        state_n   = RX_STOP;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL_LAST) begin
                        cnt_n   = '0;
                        state_n = RX_IDLE;
                        valid_n = 1'b1;
                        data_n  = shreg;
                        perr_n  = (PARITY_MODE != PARITY_NONE) && par_bad;
                        ferr_n  = !sync2;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: state_n = RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_param_core.sv
// Parameterised UART core: inline TX frame generator sharing the oversample
// tick with an independent uart_rx receive path.
module uart_param_core
    import uart_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int OVS         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tx_rx_enable,
    input  logic              tx_rx_start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_out,
    output logic              busy,
    input  logic              rx_in,
    output logic [DATA_W-1:0] rx_received_data,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err
);

    localparam int            CW        = ovs_cnt_w(OVS);
    localparam logic [CW-1:0] TICK_LAST = CW'(OVS - 1);

    tx_state_t         state, state_n;
    logic [CW-1:0]     tick_cnt, tick_cnt_n;
    logic [3:0]        bit_cnt, bit_cnt_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              par_bit, par_bit_n;
    logic              bit_done;

    assign bit_done = tx_rx_enable && (tick_cnt == TICK_LAST);
    assign busy     = (state != TX_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= TX_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
        end else begin
            state    <= state_n;
            tick_cnt <= tick_cnt_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
            par_bit  <= par_bit_n;
        end
    end

    always_comb begin
        state_n    = state;
        tick_cnt_n = tick_cnt;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        par_bit_n  = par_bit;
        if (state != TX_IDLE && tx_rx_enable)
            tick_cnt_n = bit_done ? '0 : tick_cnt + 1'b1;
        case (state)
            TX_IDLE: begin
                if (tx_rx_start) begin
                    state_n    = TX_START;
                    shreg_n    = tx_data;
                    tick_cnt_n = '0;
                    bit_cnt_n  = '0;
                    par_bit_n  = (PARITY_MODE == PARITY_ODD) ? ~^tx_data : ^tx_data;
                end
            end
            TX_START: if (bit_done) state_n = TX_DATA;
            TX_DATA: begin
                if (bit_done) begin
                    shreg_n = shreg >> 1;
                    if (bit_cnt == 4'(DATA_W - 1)) begin
                        bit_cnt_n = '0;
                        state_n   = (PARITY_MODE == PARITY_NONE) ? TX_STOP : TX_PARITY;
                    end else begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end
                end
            end
            TX_PARITY: if (bit_done) state_n = TX_STOP;
            TX_STOP: begin
                if (bit_done) begin
                    if (bit_cnt == 4'(STOP_BITS - 1))
                        state_n = TX_IDLE;
                    else
                        bit_cnt_n = bit_cnt + 4'd1;
                end
            end
            default: state_n = TX_IDLE;
        endcase
    end

    // Line level is decoded straight from registered state, so reset drives it high at once.
    always_comb begin
        tx_out = 1'b1;
        case (state)
            TX_START:  tx_out = 1'b0;
            TX_DATA:   tx_out = shreg[0];
            TX_PARITY: tx_out = par_bit;
            default:   ;
        endcase
    end

    uart_rx #(
        .DATA_W      (DATA_W),
        .PARITY_MODE (PARITY_MODE),
        .OVS         (OVS)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tx_rx_enable),
        .rx_in      (rx_in),
        .data       (rx_received_data),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err)
    );

endmodule

// File: tb/tb_uart_param_core.sv
// Bench for uart_param_core: three configurations share clock, tick and reset;
// a frame-level model feeds a per-DUT scoreboard checked by an RX monitor.
module tb_uart_param_core;

    localparam int ND = 3;
    localparam int DW [ND] = '{8, 8, 9};
    localparam int PM [ND] = '{0, 2, 1};
    localparam int SB [ND] = '{1, 2, 1};
    localparam int OV [ND] = '{16, 16, 8};

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
    } rx_exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    int         gap = 0;
    int         tests = 0;
    int         fails = 0;

    logic       start  [ND];
    logic [8:0] txd    [ND];
    logic       rx_drv [ND];
    logic       loop   [ND];
    logic       tx_line [ND];
    logic       busy   [ND];
    logic       vld    [ND];
    logic       perr   [ND];
    logic       ferr   [ND];
    logic [8:0] rdat   [ND];

    logic       tx0, tx1, tx2, bs0, bs1, bs2, v0, v1, v2;
    logic       pe0, pe1, pe2, fe0, fe1, fe2, ri0, ri1, ri2;
    logic [7:0] rd0, rd1;
    logic [8:0] rd2;

    rx_exp_t    q [ND][$];
    rx_exp_t    mon_e;

    uart_param_core #(.DATA_W(8), .PARITY_MODE(0), .STOP_BITS(1), .OVS(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .tx_rx_enable(tick), .tx_rx_start(start[0]),
        .tx_data(txd[0][7:0]), .tx_out(tx0), .busy(bs0), .rx_in(ri0),
        .rx_received_data(rd0), .valid(v0), .parity_err(pe0), .frame_err(fe0));

    uart_param_core #(.DATA_W(8), .PARITY_MODE(2), .STOP_BITS(2), .OVS(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_rx_enable(tick), .tx_rx_start(start[1]),
        .tx_data(txd[1][7:0]), .tx_out(tx1), .busy(bs1), .rx_in(ri1),
        .rx_received_data(rd1), .valid(v1), .parity_err(pe1), .frame_err(fe1));

    uart_param_core #(.DATA_W(9), .PARITY_MODE(1), .STOP_BITS(1), .OVS(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .tx_rx_enable(tick), .tx_rx_start(start[2]),
        .tx_data(txd[2]), .tx_out(tx2), .busy(bs2), .rx_in(ri2),
        .rx_received_data(rd2), .valid(v2), .parity_err(pe2), .frame_err(fe2));

    always_comb begin
        tx_line[0] = tx0; tx_line[1] = tx1; tx_line[2] = tx2;
        busy[0] = bs0;    busy[1] = bs1;    busy[2] = bs2;
        vld[0] = v0;      vld[1] = v1;      vld[2] = v2;
        perr[0] = pe0;    perr[1] = pe1;    perr[2] = pe2;
        ferr[0] = fe0;    ferr[1] = fe1;    ferr[2] = fe2;
        rdat[0] = {1'b0, rd0};
        rdat[1] = {1'b0, rd1};
        rdat[2] = rd2;
        ri0 = loop[0] ? tx0 : rx_drv[0];
        ri1 = loop[1] ? tx1 : rx_drv[1];
        ri2 = loop[2] ? tx2 : rx_drv[2];
    end

    always #5 clk = ~clk;

    // Oversample tick: one-clk pulse followed by 1..3 idle clks.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (gap == 0) begin
                tick = 1'b1;
                gap  = $urandom_range(1, 3);
            end else begin
                tick = 1'b0;
                gap--;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic int ones(input logic [8:0] v, input int w);
        int n = 0;
        for (int i = 0; i < w; i++) if (v[i]) n++;
        return n;
    endfunction

    function automatic void make_frame(input int d, input logic [8:0] v,
                                       output logic [15:0] f, output int n);
        int c;
        f    = '1;
        f[0] = 1'b0;
        n    = 1;
        for (int i = 0; i < DW[d]; i++) begin
            f[n] = v[i];
            n++;
        end
        if (PM[d] != 0) begin
            c    = ones(v, DW[d]);
            f[n] = (PM[d] == 1) ? ((c % 2) == 0) : ((c % 2) == 1);
            n++;
        end
        n += SB[d];
    endfunction

    function automatic rx_exp_t rx_model(input int d, input logic [15:0] f);
        rx_exp_t e;
        int p, tot;
        e.data = '0;
        for (int i = 0; i < DW[d]; i++) e.data[i] = f[1+i];
        p      = 1 + DW[d];
        e.perr = 1'b0;
        if (PM[d] != 0) begin
            tot    = ones(e.data, DW[d]) + (f[p] ? 1 : 0);
            e.perr = ((tot % 2) != ((PM[d] == 1) ? 1 : 0));
            p++;
        end
        e.ferr = !f[p];
        return e;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Returns at the negedge of a cycle whose following posedge carries a tick.
    task automatic wait_tick();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick && n < 20);
    endtask

    task automatic tick_step();
        wait_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_tx(input int d, input logic [8:0] v, input int abort_at, input bit intrude);
        logic [15:0] f;
        int n, ov, bt, bad, first, k;
        logic got, want;
        ov = OV[d];
        make_frame(d, v, f, n);
        @(posedge clk);
        #1;
        k = 0;
        while (busy[d] !== 1'b0 && k < 4000) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (busy[d] !== 1'b0) begin
            check($sformatf("tx_idle_wait dut%0d", d), busy[d], 0);
            return;
        end
        if (loop[d]) q[d].push_back(rx_model(d, f));
        txd[d]   = v;
        start[d] = 1'b1;
        @(posedge clk);
        #1;
        start[d] = 1'b0;
        bad = 0; first = -1; bt = 0; got = 1'b0; want = 1'b0;
        for (int j = 0; j < n * ov; j++) begin
            wait_tick();
            if (j == abort_at) begin
                rst_n = 1'b0;
                #1;
                check($sformatf("rst_line_busy_valid dut%0d", d),
                      {tx_line[d], busy[d], vld[d]}, 3'b100);
                check($sformatf("rst_rx_outputs dut%0d", d),
                      {rdat[d], perr[d], ferr[d]}, 0);
                #2;
                rst_n = 1'b1;
                return;
            end
            if (tx_line[d] !== f[j/ov]) begin
                bad++;
                if (first < 0) begin
                    first = j;
                    got   = tx_line[d];
                    want  = f[j/ov];
                end
            end
            if (busy[d] === 1'b1) bt++;
            if (intrude && j == 3 * ov) begin
                start[d] = 1'b1;
                txd[d]   = 9'h03C;
            end
            if (intrude && j == 3 * ov + 1) start[d] = 1'b0;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL tx_frame dut%0d data %0h: %0d bad ticks, first at tick %0d got %b want %b",
                     d, v, bad, first, got, want);
        end
        check($sformatf("tx_busy_ticks dut%0d", d), bt, n * ov);
        @(posedge clk);
        #1;
        check($sformatf("tx_end_busy_line dut%0d", d), {busy[d], tx_line[d]}, 2'b01);
    endtask

    task automatic drive_rx(input int d, input logic [15:0] f, input int n,
                            input bit expect_v, input int idle);
        if (expect_v) q[d].push_back(rx_model(d, f));
        for (int b = 0; b < n; b++) begin
            rx_drv[d] = f[b];
            for (int t = 0; t < OV[d]; t++) tick_step();
        end
        rx_drv[d] = 1'b1;
        for (int t = 0; t < idle; t++) tick_step();
    endtask

    task automatic rx_random(input int d);
        logic [15:0] f;
        int n, sp;
        logic [8:0] v;
        v  = 9'($urandom) & 9'((1 << DW[d]) - 1);
        make_frame(d, v, f, n);
        sp = 1 + DW[d] + ((PM[d] != 0) ? 1 : 0);
        if (PM[d] != 0 && $urandom_range(0, 3) == 0) f[sp-1] = ~f[sp-1];
        if ($urandom_range(0, 4) == 0) f[sp] = 1'b0;
        drive_rx(d, f, n, 1'b1, f[sp] ? 0 : 2 * OV[d]);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (vld[d] === 1'b1) begin
                tests++;
                if (q[d].size() == 0) begin
                    fails++;
                    $display("FAIL rx_unexpected dut%0d: got valid with data %0h, expected no frame",
                             d, rdat[d]);
                end else begin
                    mon_e = q[d].pop_front();
                    if ({rdat[d], perr[d], ferr[d]} !== {mon_e.data, mon_e.perr, mon_e.ferr}) begin
                        fails++;
                        $display("FAIL rx_frame dut%0d: got data %0h perr %b ferr %b, expected data %0h perr %b ferr %b",
                                 d, rdat[d], perr[d], ferr[d], mon_e.data, mon_e.perr, mon_e.ferr);
                    end
                end
            end
        end
    end

    initial begin
        #900000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] f;
        int n, k, busy_seen;
        for (int d = 0; d < ND; d++) begin
            start[d]  = 1'b0;
            txd[d]    = '0;
            rx_drv[d] = 1'b1;
            loop[d]   = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("reset_ctrl dut%0d", d), {tx_line[d], busy[d], vld[d], perr[d], ferr[d]}, 5'b10000);
            check($sformatf("reset_rdata dut%0d", d), rdat[d], 0);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 0xA5, no parity, looped back
        loop[0] = 1'b1;
        send_tx(0, 9'h0A5, -1, 1'b0);
        loop[0] = 1'b0;
        check("a5_rx_consumed", q[0].size(), 0);

        // even parity 0x07 looped back, then with the parity bit corrupted
        loop[1] = 1'b1;
        send_tx(1, 9'h007, -1, 1'b0);
        loop[1] = 1'b0;
        make_frame(1, 9'h007, f, n);
        f[9] = ~f[9];
        drive_rx(1, f, n, 1'b1, 0);
        check("par_err_flag", {rdat[1], perr[1], ferr[1]}, {9'h007, 2'b10});

        // break: line held low for a whole frame
        drive_rx(0, 16'h0000, 10, 1'b1, 32);
        check("break_flags", {rdat[0], perr[0], ferr[0]}, {9'h000, 2'b01});

        // glitch of 4 ticks, then a good frame
        rx_drv[0] = 1'b0;
        for (int t = 0; t < 4; t++) tick_step();
        rx_drv[0] = 1'b1;
        for (int t = 0; t < 32; t++) tick_step();
        make_frame(0, 9'h05A, f, n);
        drive_rx(0, f, n, 1'b1, 0);
        check("glitch_then_good", {rdat[0], perr[0], ferr[0]}, {9'h05A, 2'b00});

        // start request while busy is ignored
        send_tx(0, 9'h081, -1, 1'b1);
        busy_seen = 0;
        for (int t = 0; t < 48; t++) begin
            wait_tick();
            if (busy[0] !== 1'b0 || tx_line[0] !== 1'b1) busy_seen++;
        end
        check("no_extra_frame", busy_seen, 0);

        // reset during data bit 3, then a complete frame
        send_tx(0, 9'h0C3, 4 * 16 + 5, 1'b0);
        loop[0] = 1'b1;
        send_tx(0, 9'h0C3, -1, 1'b0);
        loop[0] = 1'b0;

        // randomized: TX and RX concurrently, then a couple of loopbacks
        for (int d = 0; d < ND; d++) begin
            fork
                begin
                    for (int i = 0; i < 6; i++)
                        send_tx(d, 9'($urandom) & 9'((1 << DW[d]) - 1), -1, 1'b0);
                end
                begin
                    for (int i = 0; i < 6; i++) rx_random(d);
                end
            join
            loop[d] = 1'b1;
            for (int i = 0; i < 2; i++)
                send_tx(d, 9'($urandom) & 9'((1 << DW[d]) - 1), -1, 1'b0);
            loop[d] = 1'b0;
        end

        k = 0;
        while ((q[0].size() + q[1].size() + q[2].size()) != 0 && k < 3000) begin
            @(posedge clk);
            k++;
        end
        for (int d = 0; d < ND; d++)
            check($sformatf("pending_rx dut%0d", d), q[d].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_param_core.md
UART_PARAM_CORE -- requirements
Module: uart_param_core

Interface
Parameters:
REQ-001 DATA_W, default 8, data bits per frame; legal values are 5 to 9.
REQ-002 PARITY_MODE, default 0, parity selection: 0 = none, 1 = odd, 2 = even.
REQ-003 STOP_BITS, default 1, stop bits transmitted per frame; legal values are 1 or 2.
REQ-004 OVS, default 16, oversample ticks per bit; must be even and at least 8.

Ports:
REQ-005 Clock and reset:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 Shared tick: tx_rx_enable  in  1  oversample tick; one-clk pulse, OVS pulses per bit time.
REQ-007 TX ports:
- tx_rx_start  in  1  TX request.
- tx_data  in  DATA_W  TX payload.
- tx_out  out  1  serial TX line; idle level is high.
- busy  out  1  TX frame in progress.
REQ-008 RX ports:
- rx_in  in  1  asynchronous serial RX line.
- rx_received_data  out  DATA_W  last received payload.
- valid  out  1  one-clk pulse marking a new RX frame.
- parity_err  out  1  parity status of the last RX frame.
- frame_err  out  1  stop-bit status of the last RX frame.

Function
TX:
REQ-009 A start is accepted on a clk edge where tx_rx_start=1 and busy=0; tx_data is captured and busy=1 from the next clk.
REQ-010 tx_rx_start while busy=1 is ignored; the frame in flight is unaffected.
REQ-011 TX FSM states are IDLE, START, DATA, PARITY, STOP; PARITY is skipped when PARITY_MODE=0.
REQ-012 Frame order: start bit 0, then data LSB first, then the parity bit (if enabled), then STOP_BITS stop bits of 1.
REQ-013 Each bit is held for exactly OVS tx_rx_enable ticks; the FSM advances only on ticks and freezes when there are no ticks.
REQ-014 busy clears on the clk after the final tick of the last stop bit; a new start is accepted in that same cycle.
REQ-015 Odd parity: the parity bit makes the total count of 1s in data+parity odd. Even parity: the total count is even.

RX:
REQ-016 rx_in passes through a 2-flop synchronizer, reset value 1; all RX decisions use the synchronized value.
REQ-017 RX FSM states are IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE to START on a tick where the synchronized line is 0.
REQ-019 In START, the line is sampled after OVS/2 ticks:
- sample = 1: return to IDLE (glitch reject), no valid pulse.
- sample = 0: go to DATA.
REQ-020 DATA, PARITY and STOP each sample once every OVS ticks, at mid-bit; data is shifted LSB first.
REQ-021 Only the first stop bit is checked; a sampled 0 sets frame_err for that frame.
REQ-022 On the STOP sample:
- valid pulses for one clk.
- rx_received_data, parity_err and frame_err update in the same cycle and hold until the next valid.
- The FSM returns to IDLE, so back-to-back frames are received.
REQ-023 parity_err is always 0 when PARITY_MODE=0.
REQ-024 A frame with a framing error (including break, line held at 0) still produces valid=1 with the data captured.
REQ-025 TX and RX are fully independent and may run simultaneously.

Reset
REQ-026 While rst_n=0, regardless of clk:
- tx_out=1, busy=0, valid=0.
- rx_received_data=0, parity_err=0, frame_err=0.
- Both FSMs in IDLE; counters and shift registers at 0; synchronizer flops at 1.
REQ-027 Reset mid-frame abandons the frame. After release, the next accepted start transmits a complete frame, and RX waits for a new start edge.

Structure
REQ-028 Package uart_pkg holds:
- the parity-mode constants;
- the tx_state_t and rx_state_t enums;
- the OVS-derived counter width function.
REQ-029 The RX path (synchronizer plus RX FSM) is one sub-module, uart_rx. The TX path is inline in uart_param_core.

Verification
REQ-030 Config DATA_W=8, PARITY_MODE=0, STOP_BITS=1, OVS=16. Send 0xA5:
- tx_out = 0,1,0,1,0,0,1,0,1,1, each bit 16 ticks.
- busy high for 160 ticks.
- With tx_out looped to rx_in: valid once, data 0xA5, both error flags 0.
REQ-031 PARITY_MODE=2, send 0x07: parity bit = 1. Repeat with the parity bit forced to 0 on rx_in: valid=1, data 0x07, parity_err=1.
REQ-032 rx_in held at 0 for a full frame: valid=1, data 0x00, frame_err=1.
REQ-033 rx_in low for 4 ticks then high: no valid pulse; RX back in IDLE; the next good frame is received correctly.
REQ-034 tx_rx_start with 0x3C asserted mid-frame while sending 0x81: 0x81 completes unchanged and no 0x3C frame is sent.
REQ-035 rst_n pulsed low during TX data bit 3: tx_out=1 and busy=0 immediately; the next start sends a complete, correct frame.
